// File: rtl/gmii_rx_frame_checker_pkg.sv
// Shared GMII receive constants, error-bit indices and state encoding.
// Imported by the frame checker, its CRC helper and the bench.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int ERR_CRC  = 0;
  localparam int ERR_RUNT = 1;
  localparam int ERR_OVER = 2;
  localparam int ERR_RXER = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_e;

endpackage

// File: rtl/gmii_rx_frame_checker_if.sv
// GMII receive inputs and checked frame-stream outputs.
// slave is the checker side, master the PCS/FIFO side.
interface gmii_rx_frame_checker_if;

  logic [7:0] i8_RxD;
  logic       i_RxDV;
  logic       i_RxER;

  logic [7:0] o8_Data;
  logic       o_Valid;
  logic       o_Sof;
  logic       o_Eof;
  logic       o_Good;
  logic [3:0] o4_Err;

  modport slave (
    input  i8_RxD, i_RxDV, i_RxER,
    output o8_Data, o_Valid, o_Sof,
    output o_Eof, o_Good, o4_Err
  );

  modport master (
    output i8_RxD, i_RxDV, i_RxER,
    input  o8_Data, o_Valid, o_Sof,
    input  o_Eof, o_Good, o4_Err
  );

endinterface

// File: rtl/gmii_rx_frame_checker_crc32.sv
// Combinational CRC-32 update over one byte, reflected, LSB first.
// Shared between the RX checker and the TX FCS generator.
module crc32_byte
  import gmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] result
);

  // eight unrolled shift/xor steps of the reflected polynomial
  always_comb begin
    result = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      result = result[0] ? ((result >> 1) ^ CRC_POLY)
                         : (result >> 1);
    end
  end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD/FCS, checks CRC,
// length and RxER, and emits a SOF/EOF framed byte stream.
module gmii_rx_frame_checker
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 32
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Cke,
  gmii_rx_frame_checker_if.slave bus,
  output logic [CNT_W-1:0] oN_GoodCnt,
  output logic [CNT_W-1:0] oN_BadCnt
);

  state_e      st;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [10:0] cnt;
  logic [10:0] cnt_inc;
  logic [7:0]  pipe [5];
  logic [2:0]  fill;
  logic        sent;
  logic        rxer;
  logic        full;
  logic        over;
  logic [3:0]  fin_err;

  crc32_byte u_crc (
    .crc    (crc),
    .data   (bus.i8_RxD),
    .result (crc_nxt)
  );

  // byte count, pipe fill and end-of-frame error flags
  always_comb begin
    cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    over    = {21'd0, cnt_inc} > 32'(MAX_FRAME);
    full    = fill == 3'd5;
    fin_err = '0;
    fin_err[ERR_CRC]  = crc != CRC_RESIDUE;
    fin_err[ERR_RUNT] = {21'd0, cnt} < 32'(MIN_FRAME);
    fin_err[ERR_RXER] = rxer;
  end

  // frame state machine, byte pipe, registered outputs and counters
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      st          <= S_IDLE;
      crc         <= CRC_INIT;
      cnt         <= '0;
      fill        <= '0;
      sent        <= 1'b0;
      rxer        <= 1'b0;
      for (int i = 0; i < 5; i++) pipe[i] <= '0;
      bus.o8_Data <= '0;
      bus.o_Valid <= 1'b0;
      bus.o_Sof   <= 1'b0;
      bus.o_Eof   <= 1'b0;
      bus.o_Good  <= 1'b0;
      bus.o4_Err  <= '0;
      oN_GoodCnt  <= '0;
      oN_BadCnt   <= '0;
    end else begin
      bus.o_Valid <= 1'b0;
      bus.o_Sof   <= 1'b0;
      bus.o_Eof   <= 1'b0;
      bus.o_Good  <= 1'b0;
      bus.o4_Err  <= '0;
      if (i_Cke) begin
        if (st != S_DATA) begin
          crc  <= CRC_INIT;
          cnt  <= '0;
          fill <= '0;
          sent <= 1'b0;
          rxer <= 1'b0;
        end
        unique case (st)
          S_IDLE, S_PREAMBLE: begin
            if (!bus.i_RxDV) begin
              st <= S_IDLE;
            end else begin
              unique case (1'b1)
                bus.i8_RxD == PREAMBLE: st <= S_PREAMBLE;
                bus.i8_RxD == SFD:      st <= S_DATA;
                default: begin
                  st        <= S_DROP;
                  oN_BadCnt <= oN_BadCnt + CNT_W'(1);
                end
              endcase
            end
          end
          S_DATA: begin
            if (bus.i_RxDV) begin
              crc     <= crc_nxt;
              cnt     <= cnt_inc;
              rxer    <= rxer | bus.i_RxER;
              pipe[0] <= bus.i8_RxD;
              for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
              if (!full) fill <= fill + 3'd1;
              if (full) begin
                bus.o8_Data <= pipe[4];
                bus.o_Valid <= 1'b1;
                bus.o_Sof   <= !sent;
                sent        <= 1'b1;
              end
              if (over) begin
                if (full) begin
                  bus.o_Eof            <= 1'b1;
                  bus.o4_Err[ERR_OVER] <= 1'b1;
                end
                st        <= S_DROP;
                oN_BadCnt <= oN_BadCnt + CNT_W'(1);
              end
            end else begin
              if (full) begin
                bus.o8_Data <= pipe[4];
                bus.o_Valid <= 1'b1;
                bus.o_Sof   <= !sent;
                bus.o_Eof   <= 1'b1;
                bus.o_Good  <= fin_err == 4'd0;
                bus.o4_Err  <= fin_err;
                if (fin_err == 4'd0)
                  oN_GoodCnt <= oN_GoodCnt + CNT_W'(1);
                else
                  oN_BadCnt  <= oN_BadCnt + CNT_W'(1);
              end else begin
                oN_BadCnt <= oN_BadCnt + CNT_W'(1);
              end
              st <= S_IDLE;
            end
          end
          S_DROP: begin
            if (!bus.i_RxDV) st <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Randomized bench for the GMII RX frame checker.
// Frames are scored against a frame-level reference model.
module tb_gmii_rx_frame_checker;
  import gmii_pkg::*;

  localparam int MINF = 64;
  localparam int MAXF = 1518;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cke = 1'b0;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] bad_cnt;

  gmii_rx_frame_checker_if bus ();

  gmii_rx_frame_checker #(
    .MIN_FRAME (MINF),
    .MAX_FRAME (MAXF),
    .CNT_W     (CW)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Cke      (cke),
    .bus        (bus),
    .oN_GoodCnt (good_cnt),
    .oN_BadCnt  (bad_cnt)
  );

  always #4 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int gap = 0;

  logic [7:0] fr [$];
  bit         er [$];

  int          e_n;
  logic        e_good;
  logic [3:0]  e_err;
  int unsigned m_good = 0;
  int unsigned m_bad = 0;

  logic [7:0] cap [$];
  int         sofs, sof_at, eofs, eof_at;
  logic       cap_good;
  logic [3:0] cap_err;

  // capture the output stream away from the active edge
  always @(negedge clk) begin
    if (bus.o_Valid) begin
      if (bus.o_Sof) begin
        sofs++;
        sof_at = cap.size();
      end
      if (bus.o_Eof) begin
        eofs++;
        eof_at   = cap.size();
        cap_good = bus.o_Good;
        cap_err  = bus.o4_Err;
      end
      cap.push_back(bus.o8_Data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fcs(int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, fr[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_payload(input int len, input bit incr);
    logic [31:0] f;
    fr.delete();
    er.delete();
    for (int i = 0; i < len; i++) begin
      fr.push_back(incr ? 8'(i) : 8'($urandom));
      er.push_back(1'b0);
    end
    f = ref_fcs(len);
    for (int i = 0; i < 4; i++) begin
      fr.push_back(f[8*i +: 8]);
      er.push_back(1'b0);
    end
  endtask

  task automatic put(input logic [7:0] d,
                     input logic dv, input logic e);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      cke = 1'b0;
      bus.i8_RxD = d;
      bus.i_RxDV = dv;
      bus.i_RxER = e;
    end
    @(negedge clk);
    cke = 1'b1;
    bus.i8_RxD = d;
    bus.i_RxDV = dv;
    bus.i_RxER = e;
  endtask

  task automatic clear_cap();
    cap.delete();
    sofs = 0; sof_at = -1;
    eofs = 0; eof_at = -1;
    cap_good = 1'b0; cap_err = 4'd0;
  endtask

  // kind 0: SFD + fr, kind 1: junk -> drop, kind 2: preamble abort
  task automatic model(input int kind);
    int n;
    bit rx;
    logic [31:0] fcs;
    n = fr.size();
    rx = 1'b0;
    e_n = 0; e_good = 1'b0; e_err = 4'd0;
    if (kind == 2) return;
    if (kind == 1) begin m_bad++; return; end
    if (n > MAXF) begin
      e_n = MAXF - 4;
      e_err = 4'b0100;
      m_bad++;
      return;
    end
    if (n < 5) begin m_bad++; return; end
    e_n = n - 4;
    fcs = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
    foreach (er[i]) rx |= er[i];
    e_err[0] = ref_fcs(n - 4) != fcs;
    e_err[1] = n < MINF;
    e_err[3] = rx;
    e_good = e_err == 4'd0;
    if (e_good) m_good++;
    else        m_bad++;
  endtask

  task automatic drive_frame(input int kind, input int npre);
    logic [7:0] junk;
    clear_cap();
    for (int i = 0; i < npre; i++) put(PREAMBLE, 1'b1, 1'b0);
    if (kind == 0) begin
      put(SFD, 1'b1, 1'b0);
      foreach (fr[i]) put(fr[i], 1'b1, er[i]);
    end else if (kind == 1) begin
      junk = 8'($urandom);
      while (junk == PREAMBLE || junk == SFD) junk = 8'($urandom);
      put(junk, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) put(8'($urandom), 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) put(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string t);
    check({t, ".n"}, cap.size(), e_n);
    for (int i = 0; i < e_n && i < cap.size(); i++)
      check({t, ".d"}, cap[i], fr[i]);
    check({t, ".sofs"}, sofs, (e_n > 0) ? 1 : 0);
    check({t, ".eofs"}, eofs, (e_n > 0) ? 1 : 0);
    if (e_n > 0) begin
      check({t, ".sof_at"}, sof_at, 0);
      check({t, ".eof_at"}, eof_at, e_n - 1);
      check({t, ".good"}, cap_good, e_good);
      check({t, ".err"}, cap_err, e_err);
    end
    check({t, ".gcnt"}, good_cnt, m_good);
    check({t, ".bcnt"}, bad_cnt, m_bad);
  endtask

  task automatic run(input string t, input int kind, input int npre);
    model(kind);
    drive_frame(kind, npre);
    check_frame(t);
  endtask

  initial begin
    int sel, len, k;
    bus.i8_RxD = 8'h00;
    bus.i_RxDV = 1'b0;
    bus.i_RxER = 1'b0;
    clear_cap();
    repeat (4) @(negedge clk);
    check("rst.valid", bus.o_Valid, 0);
    check("rst.data", bus.o8_Data, 0);
    check("rst.flags", {bus.o_Sof, bus.o_Eof, bus.o_Good, bus.o4_Err}, 0);
    check("rst.gcnt", good_cnt, 0);
    check("rst.bcnt", bad_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    gap = 0;
    make_payload(60, 1'b1);
    run("good64", 0, 7);

    make_payload(60, 1'b1);
    fr[10] = 8'hFF;
    run("crcerr", 0, 7);

    make_payload(40, 1'b1);
    run("runt", 0, 7);

    make_payload(1596, 1'b0);
    run("oversize", 0, 7);

    make_payload(60, 1'b0);
    er[20] = 1'b1;
    run("rxer", 0, 7);

    gap = 9;
    make_payload(60, 1'b1);
    run("cke10", 0, 7);
    gap = 0;

    make_payload(60, 1'b0);
    clear_cap();
    for (int i = 0; i < 7; i++) put(PREAMBLE, 1'b1, 1'b0);
    put(SFD, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) put(fr[i], 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_RxDV = 1'b0;
    @(negedge clk);
    check("midrst.valid", bus.o_Valid, 0);
    check("midrst.data", bus.o8_Data, 0);
    check("midrst.gcnt", good_cnt, 0);
    check("midrst.bcnt", bad_cnt, 0);
    check("midrst.eofs", eofs, 0);
    rst_n = 1'b1;
    m_good = 0;
    m_bad = 0;
    for (int i = 0; i < 3; i++) put(8'h00, 1'b0, 1'b0);
    make_payload(60, 1'b0);
    run("postrst", 0, 7);

    for (int f = 0; f < 40; f++) begin
      gap = $urandom_range(0, 2);
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        fr.delete(); er.delete();
        run("rnd.junk", 1, $urandom_range(0, 3));
      end else if (sel == 1) begin
        fr.delete(); er.delete();
        run("rnd.abort", 2, $urandom_range(1, 7));
      end else if (sel == 2) begin
        fr.delete(); er.delete();
        len = $urandom_range(0, 4);
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom));
          er.push_back(1'b0);
        end
        run("rnd.tiny", 0, $urandom_range(0, 7));
      end else begin
        make_payload($urandom_range(30, 120), 1'b0);
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, fr.size() - 1);
          fr[k] = fr[k] ^ 8'($urandom_range(1, 255));
        end
        if ($urandom_range(0, 3) == 0)
          er[$urandom_range(0, fr.size() - 1)] = 1'b1;
        run("rnd.frame", 0, $urandom_range(0, 7));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
